nn_input_feeder: RTL and testbench

- Responder end of the address-indexed read channel that a neural-network layer uses to fetch its input vector.
- Accepts one input vector as a valid/ready stream of signed Q4.4 samples and buffers it.
- Raises the layer request, then serves the layer's trigger/address reads from the buffer with one-cycle latency.
- Holds the request until the layer acknowledges, then pulses done and returns to idle for the next vector.

---
 rtl/nn_input_feeder_if.sv | 42 ++++
 rtl/nn_input_feeder.sv | 131 +++++++++++++
 tb/tb_nn_input_feeder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/nn_input_feeder_if.sv
// Bundle of the load stream, the layer request/ack pair and the layer read
// channel around nn_input_feeder.
//
// Handshake rules:
//   load stream : a sample moves on a rising clk edge where in_valid and
//                 in_ready are both high; the source holds in_data stable
//                 while in_valid is high and in_ready is low.
//   layer       : layer_req stays high until layer_ack is sampled high.
//   read port   : every cycle with rd_trig high is one read of rd_addr,
//                 answered on rd_data/rd_err one cycle later.
//
// Modports:
//   master : the loader/layer side (drives in_valid, in_data, layer_ack,
//            rd_trig, rd_addr)
//   slave  : the feeder side (drives in_ready, layer_req, rd_data, rd_err,
//            busy, done)
interface nn_input_feeder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 1
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              layer_req;
  logic              layer_ack;
  logic              rd_trig;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;
  logic              busy;
  logic              done;

  modport master (
    output in_valid, in_data, layer_ack, rd_trig, rd_addr,
    input  in_ready, layer_req, rd_data, rd_err, busy, done
  );

  modport slave (
    input  in_valid, in_data, layer_ack, rd_trig, rd_addr,
    output in_ready, layer_req, rd_data, rd_err, busy, done
  );
endinterface

// File: rtl/nn_input_feeder.sv
// nn_input_feeder: buffers one input vector of signed Q4.4 samples from a
// valid/ready stream, then requests the layer and serves its address-indexed
// reads from the buffer with one-cycle latency until the layer acknowledges.
//
// Ports:
//   clk       : clock, all logic on posedge
//   rst       : synchronous, active-high reset
//   bus       : nn_input_feeder_if.slave (load stream, layer req/ack,
//               read channel, busy/done status)
//   state_dbg : current FSM state (0 IDLE, 1 LOAD, 2 SERVE)
//
// Samples are stored and returned bit-exact; addresses compare unsigned.
// 2**ADDR_W must be >= DEPTH.
module nn_input_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 1
) (
  input  logic                clk,
  input  logic                rst,
  nn_input_feeder_if.slave    bus,
  output logic [1:0]          state_dbg
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic hs;
  logic last;
  logic rd_ok;
  logic retire;
  logic in_ready_d;
  logic busy_d;
  logic req_d;
  logic done_d;

  assign hs     = bus.in_valid & bus.in_ready;
  assign last   = (count_q == CNT_W'(DEPTH - 1));
  assign retire = (state_q == SERVE) & bus.layer_ack;
  // Extra top bit so DEPTH == 2**ADDR_W still compares correctly.
  assign rd_ok  = (state_q == SERVE) &&
                  ({1'b0, bus.rd_addr} < (ADDR_W + 1)'(DEPTH));

  assign state_dbg = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; layer_ack only matters in SERVE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, LOAD: if (hs) state_d = last ? SERVE : LOAD;
      SERVE:      if (bus.layer_ack) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Output logic: status outputs are registered from the next state so
  // layer_req rises the cycle after the final load handshake.
  always_comb begin
    in_ready_d = (state_d != SERVE);
    busy_d     = (state_d != IDLE);
    req_d      = (state_d == SERVE);
    done_d     = retire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.in_ready  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.layer_req <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.in_ready  <= in_ready_d;
      bus.busy      <= busy_d;
      bus.layer_req <= req_d;
      bus.done      <= done_d;
    end
  end

  // Load counter: cleared on the final sample and on retire so the next
  // vector always starts at index 0.
  always_ff @(posedge clk) begin
    if (rst)           count_q <= '0;
    else if (retire)   count_q <= '0;
    else if (hs)       count_q <= last ? '0 : count_q + 1'b1;
  end

  // Sample buffer; contents survive done and are overwritten by the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (hs) begin
      mem_q[count_q] <= bus.in_data;
    end
  end

  // Read port: legal reads return the buffer, illegal ones return 0 and
  // flag rd_err for one cycle; rd_data holds when no trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data <= '0;
      bus.rd_err  <= 1'b0;
    end else begin
      bus.rd_err <= 1'b0;
      if (bus.rd_trig) begin
        if (rd_ok) begin
          bus.rd_data <= mem_q[bus.rd_addr];
        end else begin
          bus.rd_data <= '0;
          bus.rd_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nn_input_feeder.sv
// Bench for nn_input_feeder: a per-cycle vector table on a DEPTH=2 instance
// and a hand-written sequence on a DEPTH=3 instance for the out-of-range
// address case.
module tb_nn_input_feeder;

  localparam logic       H   = 1'b1;
  localparam logic       L   = 1'b0;
  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_L = 2'd1;
  localparam logic [1:0] S_S = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst2;
  logic       rst3;
  logic [1:0] st2;
  logic [1:0] st3;

  nn_input_feeder_if #(.DATA_W(8), .ADDR_W(1)) bus2 ();
  nn_input_feeder_if #(.DATA_W(8), .ADDR_W(2)) bus3 ();

  nn_input_feeder #(.DATA_W(8), .DEPTH(2), .ADDR_W(1)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2), .state_dbg(st2)
  );

  nn_input_feeder #(.DATA_W(8), .DEPTH(3), .ADDR_W(2)) dut3 (
    .clk(clk), .rst(rst3), .bus(bus3), .state_dbg(st3)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // ---------------- vector table (DEPTH=2) ----------------
  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       ack;
    logic       trig;
    logic       addr;
    logic       e_ready;
    logic       e_req;
    logic [7:0] e_rd;
    logic       e_err;
    logic       e_busy;
    logic       e_done;
    logic [1:0] e_st;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  task automatic drive2(input vec_t v);
    @(negedge clk);
    rst2           = v.rst;
    bus2.in_valid  = v.valid;
    bus2.in_data   = v.data;
    bus2.layer_ack = v.ack;
    bus2.rd_trig   = v.trig;
    bus2.rd_addr   = v.addr;
    @(posedge clk);
    #1;
  endtask

  task automatic step3(input logic r, input logic v, input logic [7:0] d,
                       input logic a, input logic t, input logic [1:0] ad);
    @(negedge clk);
    rst3           = r;
    bus3.in_valid  = v;
    bus3.in_data   = d;
    bus3.layer_ack = a;
    bus3.rd_trig   = t;
    bus3.rd_addr   = ad;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst2 = 1'b1; rst3 = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.layer_ack = 1'b0;
    bus2.rd_trig = 1'b0; bus2.rd_addr = '0;
    bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.layer_ack = 1'b0;
    bus3.rd_trig = 1'b0; bus3.rd_addr = '0;

    //              rst valid data  ack trig addr | rdy req rd    err busy done st
    vecs.push_back('{H, L, 8'h00, L, L, L,  L, L, 8'h00, L, L, L, S_I}); // 0 reset
    vecs.push_back('{H, L, 8'h00, L, L, L,  L, L, 8'h00, L, L, L, S_I}); // 1 reset
    vecs.push_back('{L, L, 8'h00, L, L, L,  H, L, 8'h00, L, L, L, S_I}); // 2 idle
    vecs.push_back('{L, H, 8'h10, L, L, L,  H, L, 8'h00, L, H, L, S_L}); // 3 load 1.0
    vecs.push_back('{L, L, 8'h00, H, L, L,  H, L, 8'h00, L, H, L, S_L}); // 4 gap, ack ignored
    vecs.push_back('{L, H, 8'hF8, L, L, L,  L, H, 8'h00, L, H, L, S_S}); // 5 load -0.5
    vecs.push_back('{L, H, 8'hAA, L, H, L,  L, H, 8'h10, L, H, L, S_S}); // 6 rd0, offer ignored
    vecs.push_back('{L, L, 8'h00, L, H, H,  L, H, 8'hF8, L, H, L, S_S}); // 7 rd1 back-to-back
    vecs.push_back('{L, L, 8'h00, L, L, L,  L, H, 8'hF8, L, H, L, S_S}); // 8 hold
    vecs.push_back('{L, L, 8'h00, L, H, L,  L, H, 8'h10, L, H, L, S_S}); // 9 repeat rd0
    vecs.push_back('{L, L, 8'h00, H, L, L,  H, L, 8'h10, L, L, H, S_I}); // 10 ack -> done
    vecs.push_back('{L, L, 8'h00, L, L, L,  H, L, 8'h10, L, L, L, S_I}); // 11 done drops
    vecs.push_back('{L, L, 8'h00, L, H, L,  H, L, 8'h00, H, L, L, S_I}); // 12 read in IDLE
    vecs.push_back('{L, H, 8'h05, L, L, L,  H, L, 8'h00, L, H, L, S_L}); // 13 load 2nd vec
    vecs.push_back('{L, H, 8'h7F, L, H, H,  L, H, 8'h00, H, H, L, S_S}); // 14 read in LOAD
    vecs.push_back('{L, L, 8'h00, L, H, H,  L, H, 8'h7F, L, H, L, S_S}); // 15 rd1
    vecs.push_back('{L, L, 8'h00, H, H, L,  H, L, 8'h05, L, L, H, S_I}); // 16 ack + rd0
    vecs.push_back('{L, L, 8'h00, H, L, L,  H, L, 8'h05, L, L, L, S_I}); // 17 ack in IDLE
    vecs.push_back('{L, H, 8'h11, L, L, L,  H, L, 8'h05, L, H, L, S_L}); // 18 load 1st
    vecs.push_back('{H, H, 8'h44, L, L, L,  L, L, 8'h00, L, L, L, S_I}); // 19 reset mid-LOAD
    vecs.push_back('{L, L, 8'h00, L, L, L,  H, L, 8'h00, L, L, L, S_I}); // 20 idle
    vecs.push_back('{L, H, 8'h22, H, L, L,  H, L, 8'h00, L, H, L, S_L}); // 21 reload
    vecs.push_back('{L, H, 8'h33, L, L, L,  L, H, 8'h00, L, H, L, S_S}); // 22
    vecs.push_back('{L, L, 8'h00, L, H, L,  L, H, 8'h22, L, H, L, S_S}); // 23 rd0 new data
    vecs.push_back('{L, L, 8'h00, L, H, H,  L, H, 8'h33, L, H, L, S_S}); // 24 rd1
    vecs.push_back('{H, L, 8'h00, L, H, L,  L, L, 8'h00, L, L, L, S_I}); // 25 reset mid-SERVE
    vecs.push_back('{L, L, 8'h00, L, L, L,  H, L, 8'h00, L, L, L, S_I}); // 26 idle
    vecs.push_back('{L, L, 8'h00, L, H, L,  H, L, 8'h00, H, L, L, S_I}); // 27 read in IDLE

    for (int i = 0; i < vecs.size(); i++) begin
      drive2(vecs[i]);
      chk("in_ready",  i, {7'b0, bus2.in_ready},  {7'b0, vecs[i].e_ready});
      chk("layer_req", i, {7'b0, bus2.layer_req}, {7'b0, vecs[i].e_req});
      chk("rd_data",   i, bus2.rd_data,           vecs[i].e_rd);
      chk("rd_err",    i, {7'b0, bus2.rd_err},    {7'b0, vecs[i].e_err});
      chk("busy",      i, {7'b0, bus2.busy},      {7'b0, vecs[i].e_busy});
      chk("done",      i, {7'b0, bus2.done},      {7'b0, vecs[i].e_done});
      chk("state",     i, {6'b0, st2},            {6'b0, vecs[i].e_st});
    end

    // ---------------- DEPTH=3 hand sequence ----------------
    step3(H, L, 8'h00, L, L, 2'd0);
    step3(H, L, 8'h00, L, L, 2'd0);
    chk("d3_rst_ready", 0, {7'b0, bus3.in_ready},  8'h00);
    chk("d3_rst_req",   0, {7'b0, bus3.layer_req}, 8'h00);
    chk("d3_rst_rd",    0, bus3.rd_data,           8'h00);
    chk("d3_rst_busy",  0, {7'b0, bus3.busy},      8'h00);
    step3(L, L, 8'h00, L, L, 2'd0);
    chk("d3_idle_ready", 1, {7'b0, bus3.in_ready}, 8'h01);
    chk("d3_idle_state", 1, {6'b0, st3},           {6'b0, S_I});

    step3(L, H, 8'h01, L, L, 2'd0);
    chk("d3_load_state", 2, {6'b0, st3}, {6'b0, S_L});
    step3(L, L, 8'h00, L, L, 2'd0);
    chk("d3_gap_state", 3, {6'b0, st3}, {6'b0, S_L});
    step3(L, H, 8'h82, L, H, 2'd0);
    chk("d3_ldrd_err",   4, {7'b0, bus3.rd_err}, 8'h01);
    chk("d3_ldrd_data",  4, bus3.rd_data,        8'h00);
    chk("d3_ldrd_state", 4, {6'b0, st3},         {6'b0, S_L});
    step3(L, H, 8'h7E, L, L, 2'd0);
    chk("d3_req",        5, {7'b0, bus3.layer_req}, 8'h01);
    chk("d3_serve_rdy",  5, {7'b0, bus3.in_ready},  8'h00);

    exp_q.push_back(8'h7E);
    step3(L, H, 8'h55, L, H, 2'd2);
    chk("d3_rd2",     6, bus3.rd_data, exp_q.pop_front());
    chk("d3_rd2_err", 6, {7'b0, bus3.rd_err}, 8'h00);
    chk("d3_rd2_rdy", 6, {7'b0, bus3.in_ready}, 8'h00);

    step3(L, L, 8'h00, L, H, 2'd3);
    chk("d3_oob_data",  7, bus3.rd_data,          8'h00);
    chk("d3_oob_err",   7, {7'b0, bus3.rd_err},   8'h01);
    chk("d3_oob_state", 7, {6'b0, st3},           {6'b0, S_S});
    chk("d3_oob_req",   7, {7'b0, bus3.layer_req}, 8'h01);

    exp_q.push_back(8'h82);
    step3(L, L, 8'h00, L, H, 2'd1);
    chk("d3_rd1",     8, bus3.rd_data, exp_q.pop_front());
    chk("d3_rd1_err", 8, {7'b0, bus3.rd_err}, 8'h00);

    exp_q.push_back(8'h01);
    step3(L, L, 8'h00, L, H, 2'd0);
    chk("d3_rd0", 9, bus3.rd_data, exp_q.pop_front());

    exp_q.push_back(8'h7E);
    step3(L, L, 8'h00, H, H, 2'd2);
    chk("d3_ackrd",    10, bus3.rd_data, exp_q.pop_front());
    chk("d3_ack_done", 10, {7'b0, bus3.done},      8'h01);
    chk("d3_ack_req",  10, {7'b0, bus3.layer_req}, 8'h00);
    chk("d3_ack_state",10, {6'b0, st3},            {6'b0, S_I});

    step3(L, L, 8'h00, L, L, 2'd0);
    chk("d3_done_low", 11, {7'b0, bus3.done},     8'h00);
    chk("d3_busy_low", 11, {7'b0, bus3.busy},     8'h00);
    chk("d3_rdy_back", 11, {7'b0, bus3.in_ready}, 8'h01);
    chk("d3_rd_hold",  11, bus3.rd_data,          8'h7E);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
